// File: rtl/iu_shared_divider_pkg.sv
// iu_shared_divider_pkg: shared types and constants for the thread-shared divider
package iu_shared_divider_pkg;
    localparam int NTHREADIDMSB = 2;
    localparam int DIV_ITERS_DEF = 32;
    typedef struct packed {
        logic clk;
    } iu_clk_type;
    typedef enum logic [2:0] {c_NOMUL, c_UMUL, c_SMUL, c_UMAC, c_SMAC, c_UDIV, c_SDIV} mul_ctrl_type;
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } alu_flag_type;
    typedef enum bit [1:0] {DIV_IDLE, DIV_BUSY, DIV_FIXUP, DIV_DONE} div_state_type;
    typedef struct packed {
        logic [NTHREADIDMSB:0] tid;
        mul_ctrl_type          mode;
        logic [31:0]           y;
        logic [31:0]           op1;
        logic [31:0]           op2;
        logic                  op2zero;
    } div_req_type;
endpackage

// File: rtl/iu_div_step.sv
// iu_div_step: one combinational restoring shift-subtract step of the divider
module iu_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);
    logic [32:0] sh;
    logic        ge;
    // shift rem:quo left, keep the difference when the divisor fits
    always_comb begin
        sh    = {rem_i, quo_i[31]};
        ge    = sh >= {1'b0, dvs_i};
        rem_o = ge ? 32'(sh - {1'b0, dvs_i}) : sh[31:0];
        quo_o = {quo_i[30:0], ge};
    end
endmodule

// File: rtl/iu_shared_divider.sv
// iu_shared_divider: single-owner iterative radix-2 divider shared by all threads
module iu_shared_divider
    import iu_shared_divider_pkg::*;
#(
    parameter int DIV_ITERS = DIV_ITERS_DEF
) (
    input  iu_clk_type            gclk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [NTHREADIDMSB:0] req_tid,
    input  mul_ctrl_type          req_mode,
    input  logic [31:0]           req_y,
    input  logic [31:0]           req_op1,
    input  logic [31:0]           req_op2,
    input  logic                  req_op2zero,
    input  logic                  flush,
    input  logic [NTHREADIDMSB:0] flush_tid,
    output logic                  resp_valid,
    output logic                  resp_replay,
    output logic [31:0]           resp_result,
    output alu_flag_type          resp_flag,
    output logic                  resp_divz,
    output logic                  busy
);
    div_state_type         state_q, state_d;
    logic [NTHREADIDMSB:0] owner_q, owner_d;
    logic [5:0]            cnt_q, cnt_d;
    logic                  sgn_q, sgn_d, neg_q, neg_d, ovf_hi_q, ovf_hi_d;
    logic [31:0]           rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
    alu_flag_type          flg_q, flg_d, flag_q, flag_d;
    logic                  valid_q, valid_d, replay_q, replay_d, divz_q, divz_d;
    logic [31:0]           result_q, result_d;
    logic [31:0]           step_rem, step_quo, fix_q;
    logic                  req, is_sdiv, kill, dvd_neg, dvs_neg, fix_ovf;
    logic [63:0]           dvd_abs;
    logic [31:0]           dvs_abs;

    iu_div_step u_step (
        .rem_i(rem_q),
        .quo_i(quo_q),
        .dvs_i(dvs_q),
        .rem_o(step_rem),
        .quo_o(step_quo)
    );

    assign busy        = state_q != DIV_IDLE;
    assign resp_valid  = valid_q;
    assign resp_replay = replay_q;
    assign resp_result = result_q;
    assign resp_flag   = flag_q;
    assign resp_divz   = divz_q;

    // operand magnitudes, signed-result fixup and saturation
    always_comb begin
        is_sdiv = req_mode == c_SDIV;
        req     = req_valid && (req_mode == c_UDIV || is_sdiv);
        kill    = flush && flush_tid == owner_q && state_q != DIV_IDLE;
        dvd_neg = is_sdiv && req_y[31];
        dvs_neg = is_sdiv && req_op2[31];
        dvd_abs = dvd_neg ? -{req_y, req_op1} : {req_y, req_op1};
        dvs_abs = dvs_neg ? -req_op2 : req_op2;
        fix_ovf = ovf_hi_q || (sgn_q && (neg_q ? quo_q > 32'h8000_0000 : quo_q[31]));
        fix_q   = fix_ovf ? (!sgn_q ? 32'hffff_ffff : neg_q ? 32'h8000_0000 : 32'h7fff_ffff)
                          : (neg_q ? -quo_q : quo_q);
    end

    // next-state and registered response
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        neg_d    = neg_q;
        ovf_hi_d = ovf_hi_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        res_d    = res_q;
        flg_d    = flg_q;
        valid_d  = 1'b0;
        replay_d = 1'b0;
        divz_d   = 1'b0;
        result_d = '0;
        flag_d   = '0;
        case (state_q)
            DIV_IDLE: if (req) begin
                if (req_op2zero) begin
                    valid_d = 1'b1;
                    divz_d  = 1'b1;
                end else begin
                    owner_d  = req_tid;
                    sgn_d    = is_sdiv;
                    neg_d    = dvd_neg ^ dvs_neg;
                    ovf_hi_d = dvd_abs[63:32] >= dvs_abs;
                    rem_d    = dvd_abs[63:32];
                    quo_d    = dvd_abs[31:0];
                    dvs_d    = dvs_abs;
                    cnt_d    = '0;
                    replay_d = 1'b1;
                    state_d  = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                replay_d = req;
                rem_d    = step_rem;
                quo_d    = step_quo;
                cnt_d    = cnt_q + 6'd1;
                state_d  = cnt_q == 6'(DIV_ITERS - 1) ? DIV_FIXUP : DIV_BUSY;
            end
            DIV_FIXUP: begin
                replay_d = req;
                res_d    = fix_q;
                flg_d    = '{n: fix_q[31], z: fix_q == 32'd0, v: fix_ovf, c: 1'b0};
                state_d  = DIV_DONE;
            end
            default: if (req) begin
                if (req_tid == owner_q && !kill) begin
                    valid_d  = 1'b1;
                    result_d = res_q;
                    flag_d   = flg_q;
                    state_d  = DIV_IDLE;
                end else begin
                    replay_d = 1'b1;
                end
            end
        endcase
        if (kill) state_d = DIV_IDLE;
    end

    // state, datapath and output registers
    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            owner_q  <= '0;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            ovf_hi_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            valid_q  <= 1'b0;
            replay_q <= 1'b0;
            divz_q   <= 1'b0;
            result_q <= '0;
            flag_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            neg_q    <= neg_d;
            ovf_hi_q <= ovf_hi_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            valid_q  <= valid_d;
            replay_q <= replay_d;
            divz_q   <= divz_d;
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end
endmodule

// File: tb/tb_iu_shared_divider.sv
// tb_iu_shared_divider: directed checks of the shared divider
module tb_iu_shared_divider;
    import iu_shared_divider_pkg::*;
    logic         clk = 1'b0;
    iu_clk_type   gclk;
    logic         rst = 1'b1, req_valid = 1'b0, req_op2zero = 1'b0, flush = 1'b0;
    logic [2:0]   req_tid = '0, flush_tid = '0;
    mul_ctrl_type req_mode = c_NOMUL;
    logic [31:0]  req_y = '0, req_op1 = '0, req_op2 = '0;
    logic         resp_valid, resp_replay, resp_divz, busy;
    logic [31:0]  resp_result;
    alu_flag_type resp_flag;
    logic [38:0]  rsp;
    int           checks = 0, errors = 0;

    assign gclk.clk = clk;
    assign rsp = {resp_valid, resp_replay, resp_divz, resp_flag, resp_result};
    always #5 clk = ~clk;

    iu_shared_divider dut (
        .gclk(gclk), .rst(rst), .req_valid(req_valid), .req_tid(req_tid), .req_mode(req_mode),
        .req_y(req_y), .req_op1(req_op1), .req_op2(req_op2), .req_op2zero(req_op2zero),
        .flush(flush), .flush_tid(flush_tid), .resp_valid(resp_valid), .resp_replay(resp_replay),
        .resp_result(resp_result), .resp_flag(resp_flag), .resp_divz(resp_divz), .busy(busy)
    );

    function automatic logic [38:0] exp_rsp(input logic v, r, d, input logic [3:0] f, input logic [31:0] q);
        return {v, r, d, f, q};
    endfunction

    localparam logic [38:0] REPLAY = {3'b010, 36'd0};

    task automatic do_req(input logic [2:0] tid, input mul_ctrl_type m, input logic [31:0] y, a, b, input logic z);
        req_valid = 1'b1; req_tid = tid; req_mode = m; req_y = y; req_op1 = a; req_op2 = b; req_op2zero = z;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op2zero = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        checks++; if (rsp !== 39'd0) begin errors++; $display("FAIL reset_outputs got %h exp %h", rsp, 39'd0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_udiv;
        do_req(3, c_UDIV, 0, 100, 7, 0);
        checks++; if (rsp !== REPLAY) begin errors++; $display("FAIL udiv_accept got %h exp %h", rsp, REPLAY); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL udiv_busy got %b exp 1", busy); end
        idle(32);
        do_req(3, c_UDIV, 0, 100, 7, 0);
        checks++; if (rsp !== REPLAY) begin errors++; $display("FAIL udiv_fixup_replay got %h exp %h", rsp, REPLAY); end
        do_req(3, c_UDIV, 0, 100, 7, 0);
        checks++; if (rsp !== exp_rsp(1, 0, 0, 4'b0000, 32'd14)) begin errors++; $display("FAIL udiv_collect got %h exp %h", rsp, exp_rsp(1, 0, 0, 4'b0000, 32'd14)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL udiv_idle got %b exp 0", busy); end
        idle(1);
        checks++; if (rsp !== 39'd0) begin errors++; $display("FAIL udiv_quiet got %h exp 0", rsp); end
    endtask

    task automatic test_sdiv;
        do_req(1, c_SDIV, 32'hffff_ffff, 32'hffff_ff9c, 7, 0);
        checks++; if (rsp !== REPLAY) begin errors++; $display("FAIL sdiv_accept got %h exp %h", rsp, REPLAY); end
        idle(33);
        do_req(1, c_SDIV, 0, 0, 0, 0);
        checks++; if (rsp !== exp_rsp(1, 0, 0, 4'b1000, 32'hffff_fff2)) begin errors++; $display("FAIL sdiv_collect got %h exp %h", rsp, exp_rsp(1, 0, 0, 4'b1000, 32'hffff_fff2)); end
    endtask

    task automatic test_overflow;
        mul_ctrl_type tm[4] = '{c_UDIV, c_SDIV, c_SDIV, c_SDIV};
        logic [31:0] ty[4] = '{32'h1, 32'h0, 32'hffff_ffff, 32'hffff_ffff};
        logic [31:0] ta[4] = '{32'h0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb[4] = '{32'h1, 32'h1, 32'h1, 32'hffff_ffff};
        logic [31:0] tq[4] = '{32'hffff_ffff, 32'h7fff_ffff, 32'h8000_0000, 32'h7fff_ffff};
        logic [3:0]  tf[4] = '{4'b1010, 4'b0010, 4'b1000, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            do_req(1, tm[i], ty[i], ta[i], tb[i], 0);
            checks++; if (rsp !== REPLAY) begin errors++; $display("FAIL ovf_accept_%0d got %h exp %h", i, rsp, REPLAY); end
            idle(33);
            do_req(1, tm[i], 0, 0, 0, 0);
            checks++; if (rsp !== exp_rsp(1, 0, 0, tf[i], tq[i])) begin errors++; $display("FAIL ovf_collect_%0d got %h exp %h", i, rsp, exp_rsp(1, 0, 0, tf[i], tq[i])); end
        end
    endtask

    task automatic test_divz;
        do_req(0, c_UDIV, 0, 5, 0, 1);
        checks++; if (rsp !== exp_rsp(1, 0, 1, 4'b0000, 32'd0)) begin errors++; $display("FAIL divz_idle got %h exp %h", rsp, exp_rsp(1, 0, 1, 4'b0000, 32'd0)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divz_busy got %b exp 0", busy); end
        do_req(4, c_UDIV, 0, 5, 3, 0);
        idle(3);
        do_req(6, c_UDIV, 0, 5, 0, 1);
        checks++; if (rsp !== REPLAY) begin errors++; $display("FAIL divz_while_busy got %h exp %h", rsp, REPLAY); end
        flush = 1'b1; flush_tid = 4;
        idle(1);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divz_flush_idle got %b exp 0", busy); end
    endtask

    task automatic test_contention;
        do_req(2, c_UDIV, 0, 1000, 10, 0);
        idle(9);
        do_req(5, c_SDIV, 0, 8, 2, 0);
        checks++; if (rsp !== REPLAY) begin errors++; $display("FAIL other_busy got %h exp %h", rsp, REPLAY); end
        idle(29);
        do_req(5, c_SDIV, 0, 8, 2, 0);
        checks++; if (rsp !== REPLAY) begin errors++; $display("FAIL other_done got %h exp %h", rsp, REPLAY); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL result_held got %b exp 1", busy); end
        idle(9);
        do_req(2, c_UDIV, 0, 0, 0, 0);
        checks++; if (rsp !== exp_rsp(1, 0, 0, 4'b0000, 32'd100)) begin errors++; $display("FAIL owner_collect got %h exp %h", rsp, exp_rsp(1, 0, 0, 4'b0000, 32'd100)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL owner_idle got %b exp 0", busy); end
    endtask

    task automatic test_flush;
        do_req(3, c_SDIV, 0, 50, 5, 0);
        idle(18);
        flush = 1'b1; flush_tid = 1;
        idle(1);
        flush = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_other got %b exp 1", busy); end
        flush = 1'b1; flush_tid = 3;
        do_req(3, c_SDIV, 0, 50, 5, 0);
        flush = 1'b0;
        checks++; if (rsp !== REPLAY) begin errors++; $display("FAIL flush_owner_req got %h exp %h", rsp, REPLAY); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle got %b exp 0", busy); end
        do_req(3, c_SDIV, 0, 50, 5, 0);
        checks++; if (rsp !== REPLAY || busy !== 1'b1) begin errors++; $display("FAIL flush_reaccept got %h/%b exp %h/1", rsp, busy, REPLAY); end
        idle(33);
        do_req(3, c_SDIV, 0, 0, 0, 0);
        checks++; if (rsp !== exp_rsp(1, 0, 0, 4'b0000, 32'd10)) begin errors++; $display("FAIL flush_collect got %h exp %h", rsp, exp_rsp(1, 0, 0, 4'b0000, 32'd10)); end
    endtask

    task automatic test_rst_mid;
        do_req(7, c_UDIV, 0, 9, 3, 0);
        idle(14);
        rst = 1'b1;
        do_req(7, c_UDIV, 0, 9, 3, 0);
        rst = 1'b0;
        checks++; if (rsp !== 39'd0) begin errors++; $display("FAIL rst_mid_outputs got %h exp 0", rsp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        do_req(7, c_UDIV, 0, 9, 3, 0);
        checks++; if (rsp !== REPLAY) begin errors++; $display("FAIL rst_reaccept got %h exp %h", rsp, REPLAY); end
        idle(33);
        do_req(7, c_UDIV, 0, 0, 0, 0);
        checks++; if (rsp !== exp_rsp(1, 0, 0, 4'b0000, 32'd3)) begin errors++; $display("FAIL rst_collect got %h exp %h", rsp, exp_rsp(1, 0, 0, 4'b0000, 32'd3)); end
    endtask

    initial begin
        test_reset;
        test_udiv;
        test_sdiv;
        test_overflow;
        test_divz;
        test_contention;
        test_flush;
        test_rst_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
